// File: rtl/store_trace_buffer_if.sv
// Bus bundle between the CPU MEM stage / trace consumer and the store trace buffer.
// The slave modport is the buffer side; the master modport drives stores and consumes the trace.
interface store_trace_buffer_if #(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 16
);
  logic                     MemWrite_MEM;
  logic [31:0]              ALU_Result_MEM;
  logic [31:0]              Write_Data_MUX_MEM;
  logic                     Capture_En;
  logic                     Trace_Ready;
  logic                     Clear_Overflow;
  logic                     Trace_Valid;
  logic [31:0]              Trace_Addr;
  logic [31:0]              Trace_Data;
  logic [SEQ_W-1:0]         Trace_Seq;
  logic                     Trace_Misaligned;
  logic [$clog2(DEPTH):0]   Count;
  logic                     Full;
  logic                     Empty;
  logic                     Overflow;
  logic [15:0]              Drop_Count;

  modport slave (
    input  MemWrite_MEM, ALU_Result_MEM, Write_Data_MUX_MEM,
           Capture_En, Trace_Ready, Clear_Overflow,
    output Trace_Valid, Trace_Addr, Trace_Data, Trace_Seq, Trace_Misaligned,
           Count, Full, Empty, Overflow, Drop_Count
  );

  modport master (
    output MemWrite_MEM, ALU_Result_MEM, Write_Data_MUX_MEM,
           Capture_En, Trace_Ready, Clear_Overflow,
    input  Trace_Valid, Trace_Addr, Trace_Data, Trace_Seq, Trace_Misaligned,
           Count, Full, Empty, Overflow, Drop_Count
  );
endinterface

// File: rtl/store_trace_buffer.sv
// Captures CPU store events into a first-word-fall-through FIFO with sequence stamps,
// registered head outputs and sticky overflow / saturating drop accounting.
module store_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 16
) (
  input logic                Clk,
  input logic                Reset_n,
  store_trace_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]      mem_addr [0:DEPTH-1];
  logic [31:0]      mem_data [0:DEPTH-1];
  logic [SEQ_W-1:0] mem_seq  [0:DEPTH-1];
  logic             mem_mis  [0:DEPTH-1];

  logic [PW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic             full_q, empty_q;
  logic [SEQ_W-1:0] seq_cnt;
  logic             overflow_q;
  logic [15:0]      drop_cnt;
  logic [31:0]      head_addr, head_data;
  logic [SEQ_W-1:0] head_seq;
  logic             head_mis;

  logic store_event, do_pop, do_push, do_drop, in_mis, bypass, load_head;

  // Head refresh: when the entry that becomes head is written this very edge, take it straight from the inputs.
  always_comb begin
    store_event = bus.MemWrite_MEM && bus.Capture_En;
    do_pop      = !empty_q && bus.Trace_Ready;
    do_push     = store_event && (!full_q || do_pop);
    do_drop     = store_event && full_q && !do_pop;
    count_nxt   = count + CW'(do_push) - CW'(do_pop);
    rd_ptr_nxt  = rd_ptr + PW'(do_pop);
    in_mis      = |bus.ALU_Result_MEM[1:0];
    bypass      = do_push && (count == CW'(do_pop));
    load_head   = (count_nxt != '0) && (do_pop || empty_q);
  end

  always_ff @(posedge Clk) begin
    if (Reset_n && do_push) begin
      mem_addr[wr_ptr] <= bus.ALU_Result_MEM;
      mem_data[wr_ptr] <= bus.Write_Data_MUX_MEM;
      mem_seq[wr_ptr]  <= seq_cnt;
      mem_mis[wr_ptr]  <= in_mis;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      seq_cnt    <= '0;
      overflow_q <= 1'b0;
      drop_cnt   <= '0;
      head_addr  <= '0;
      head_data  <= '0;
      head_seq   <= '0;
      head_mis   <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + PW'(do_push);
      rd_ptr  <= rd_ptr_nxt;
      count   <= count_nxt;
      full_q  <= (count_nxt == FULL_CNT);
      empty_q <= (count_nxt == '0);
      if (store_event) seq_cnt <= seq_cnt + SEQ_W'(1);
      // A drop in the same cycle as a clear still leaves one recorded loss.
      if (do_drop) begin
        overflow_q <= 1'b1;
        if (bus.Clear_Overflow)      drop_cnt <= 16'd1;
        else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end else if (bus.Clear_Overflow) begin
        overflow_q <= 1'b0;
        drop_cnt   <= '0;
      end
      if (load_head) begin
        if (bypass) begin
          head_addr <= bus.ALU_Result_MEM;
          head_data <= bus.Write_Data_MUX_MEM;
          head_seq  <= seq_cnt;
          head_mis  <= in_mis;
        end else begin
          head_addr <= mem_addr[rd_ptr_nxt];
          head_data <= mem_data[rd_ptr_nxt];
          head_seq  <= mem_seq[rd_ptr_nxt];
          head_mis  <= mem_mis[rd_ptr_nxt];
        end
      end
    end
  end

  assign bus.Trace_Valid      = !empty_q;
  assign bus.Trace_Addr       = head_addr;
  assign bus.Trace_Data       = head_data;
  assign bus.Trace_Seq        = head_seq;
  assign bus.Trace_Misaligned = head_mis;
  assign bus.Count            = count;
  assign bus.Full             = full_q;
  assign bus.Empty            = empty_q;
  assign bus.Overflow         = overflow_q;
  assign bus.Drop_Count       = drop_cnt;
endmodule

// File: doc/store_trace_buffer.md
STORE_TRACE_BUFFER -- requirements
Module: store_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, 4 to 64.
REQ-002 SHALL have parameter SEQ_W, default 16, width of store sequence stamp.
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port MemWrite_MEM  input  1  CPU MEM-stage store strobe; one store per high cycle.
REQ-006 SHALL have port ALU_Result_MEM  input  32  store byte address.
REQ-007 SHALL have port Write_Data_MUX_MEM  input  32  store data.
REQ-008 SHALL have port Capture_En  input  1  when low, stores are neither captured nor counted.
REQ-009 SHALL have port Trace_Ready  input  1  consumer accepts the head entry.
REQ-010 SHALL have port Clear_Overflow  input  1  clears Overflow and Drop_Count.
REQ-011 SHALL have port Trace_Valid  output  1  head entry present.
REQ-012 SHALL have port Trace_Addr  output  32  head entry address.
REQ-013 SHALL have port Trace_Data  output  32  head entry data.
REQ-014 SHALL have port Trace_Seq  output  SEQ_W  head entry sequence stamp.
REQ-015 SHALL have port Trace_Misaligned  output  1  head entry address[1:0] != 0.
REQ-016 SHALL have port Count  output  log2(DEPTH)+1  occupancy.
REQ-017 SHALL have ports Full, Empty  output  1 each  occupancy flags.
REQ-018 SHALL have port Overflow  output  1  sticky: a store was lost.
REQ-019 SHALL have port Drop_Count  output  16  number of lost stores, saturating.

Function
REQ-020 SHALL push {addr, data, seq, misaligned} when MemWrite_MEM=1 and Capture_En=1 (a "store event").
REQ-021 SHALL stamp each store event with the current sequence counter, then increment it modulo 2^SEQ_W; dropped events also consume a sequence value, exposing the gap.
REQ-022 SHALL present the head entry first-word-fall-through: Trace_Valid = !Empty; fields valid whenever Trace_Valid=1, otherwise hold last value.
REQ-023 SHALL pop when Trace_Valid=1 and Trace_Ready=1 on a rising edge; Trace_Ready while Empty has no effect.
REQ-024 SHALL make a pushed entry visible at outputs the cycle after the push edge (latency 1) when FIFO was empty.
REQ-025 SHALL, on simultaneous push and pop, keep Count unchanged, including when Full (push accepted, no drop).
REQ-026 SHALL, on push while Full without pop, discard the event, set Overflow, increment Drop_Count saturating at 16'hFFFF.
REQ-027 SHALL, when Clear_Overflow coincides with a drop, leave Overflow=1 and Drop_Count=1 (new drop wins).
REQ-028 SHALL wrap read/write pointers modulo DEPTH without loss or duplication.
REQ-029 SHALL assert Full iff Count=DEPTH and Empty iff Count=0, registered consistent with Count each cycle.
REQ-030 SHALL contain no combinational path from Trace_Ready to any output other than via registered state.

Reset
REQ-031 SHALL, on rising Clk with Reset_n=0, set Count=0, Empty=1, Full=0, Trace_Valid=0, Overflow=0, Drop_Count=0, sequence counter=0, pointers=0, Trace_Addr/Data/Seq/Misaligned=0.
REQ-032 SHALL give reset priority over store events, pops and Clear_Overflow in the same cycle; entries in flight are discarded.
REQ-033 SHALL accept a store event on the first edge after Reset_n returns high, stamped Seq=0.

Verification
REQ-034 Single store addr=0x10, data=0xDEADBEEF, empty FIFO, Trace_Ready=0 -> next cycle Trace_Valid=1, Addr=0x10, Data=0xDEADBEEF, Seq=0, Misaligned=0, Count=1.
REQ-035 DEPTH=16, 18 consecutive stores, Trace_Ready=0 -> Full=1, Count=16, Overflow=1, Drop_Count=2; draining yields Seq 0..15 in order.
REQ-036 Full FIFO, store with Trace_Ready=1 same cycle -> Count stays 16, Overflow stays 0, new entry Seq=16 appears last.
REQ-037 Store addr=0x13 with Capture_En=0 then addr=0x13 with Capture_En=1 -> only one entry, Seq=0, Misaligned=1.
REQ-038 Three entries queued, Reset_n=0 one cycle concurrent with store and Trace_Ready=1 -> Empty=1, Count=0, Trace_Valid=0; next store stamped Seq=0.
REQ-039 40 push/pop cycles with random Trace_Ready, pointers wrapping twice -> scoreboard matches every accepted entry, no gaps except counted drops.
